write_driver: RTL
=================

// Module: write_driver
// PURPOSE
//  Write-back address/strobe generator for the FFT butterfly pipeline; counterpart of read_driver.
//  Captures each read issued to the data RAM (i_rden plus the A/B addresses), delays it by the
//  butterfly pipeline latency, then writes the butterfly results back to the same A/B addresses.
//  Counts completed write pairs, pulses o_pass_done at the end of each pass, flags short passes.
// PARAMETERS
//  ADDR_SIZE       5   data-RAM address width (A and B ports)
//  DATA_WIDTH      32  width of one butterfly result word (packed re/im)
//  PIPE_LATENCY    3   cycles from a sampled i_rden to valid i_bfly_* data; legal range >= 1
//  PAIRS_PER_PASS  4   write pairs per pass; legal range 1..2**(ADDR_SIZE-1)
// PORTS
//  i_CLK        in   1            clock, all logic on rising edge
//  i_RST        in   1            synchronous reset, active-high
//  i_rden       in   1            read strobe from read_driver; one tag is created per high cycle
//  i_rdaddr_A   in   ADDR_SIZE    read address A, sampled with i_rden
//  i_rdaddr_B   in   ADDR_SIZE    read address B, sampled with i_rden
//  i_bfly_A     in   DATA_WIDTH   butterfly upper output
//  i_bfly_B     in   DATA_WIDTH   butterfly lower output
//  o_wren       out  1            RAM write enable (both ports)
//  o_wraddr_A   out  ADDR_SIZE    write address A
//  o_wraddr_B   out  ADDR_SIZE    write address B
//  o_wrdata_A   out  DATA_WIDTH   write data A
//  o_wrdata_B   out  DATA_WIDTH   write data B
//  o_busy       out  1            high while any tag is in flight or a pass is open
//  o_pass_done  out  1            one-cycle pulse after the last write of a pass
//  o_err_short  out  1            sticky: pipeline drained with 0 < count < PAIRS_PER_PASS
// BEHAVIOUR
//  Reset (sync, i_RST=1 at an edge): all outputs 0, tag line cleared, count=0, state=IDLE.
//   Reset mid-pass discards in-flight tags; no o_wren may follow from pre-reset reads.
//  Tag line: PIPE_LATENCY-stage shift register of {v, addrA, addrB}. It never stalls.
//   Stage0 <= {i_rden, i_rdaddr_A, i_rdaddr_B} every cycle.
//  Timing: i_rden sampled at edge k -> i_bfly_* must be valid before edge k+PIPE_LATENCY.
//   At edge k+PIPE_LATENCY: o_wren<=1, o_wraddr_*<=tag addrs, o_wrdata_*<=i_bfly_*.
//   When the final-stage tag is invalid: o_wren<=0; addr/data outputs hold their last value.
//  Back-to-back i_rden produces back-to-back o_wren, same order, no gaps and no merging.
//  Pair counter: width clog2(PAIRS_PER_PASS+1); increments on each write issue.
//   A write at count==PAIRS_PER_PASS-1 wraps count to 0 and pulses o_pass_done 1 cycle
//   later, coincident with o_wren low or high as the tag stream dictates.
//  FSM:
//   IDLE   : o_busy=0. i_rden=1 -> ACTIVE.
//   ACTIVE : o_busy=1. Pass-completing write -> DONE.
//            Tag line empty and i_rden=0 with count>0 -> ERR.
//   DONE   : o_pass_done=1 for this one cycle. Next: ACTIVE if any tag valid or i_rden=1,
//            else IDLE. Reads arriving during DONE are tagged normally.
//   ERR    : set o_err_short (sticky until reset), count<=0, -> IDLE.
//  Simultaneous events: a new i_rden in the same cycle as a pass-completing write belongs to
//   the next pass. A write never double-counts. o_err_short is not cleared by o_pass_done.
//  Addresses are passed through unmodified. No A==B check. No arithmetic on data.
// TESTING
//  1. Reset, then 4 consecutive i_rden with A/B=(0,1),(2,3),(4,5),(6,7), and i_bfly_A=addrA+100
//     -> o_wren high for 4 cycles starting 3 edges after the first read; addresses match in
//     order; o_pass_done pulses once the following cycle; FSM returns to IDLE and o_busy=0.
//  2. Two passes back-to-back (8 reads with no gap) -> 8 contiguous writes; o_pass_done pulses
//     twice; o_err_short stays 0.
//  3. Gapped reads (rden 1,0,1,0,...) -> writes reproduce the same gap pattern, shifted by
//     PIPE_LATENCY; data sampled on the correct cycles.
//  4. 2 reads, then idle -> 2 writes, then o_err_short=1 (sticky); no o_pass_done;
//     the next full 4-read pass completes normally with o_err_short still 1.
//  5. Assert i_RST one cycle after the 2nd of 4 reads -> no o_wren after reset; all outputs 0;
//     count=0.
//  6. Sweep PIPE_LATENCY=1 and 5 with test 1 stimulus -> write lag equals PIPE_LATENCY.

Source files
------------

// File: rtl/write_driver.sv
// Write-back address/strobe generator for the FFT butterfly pipeline: delays each RAM read
// by the butterfly latency, writes the results back to the same A/B addresses, and tracks passes.
module write_driver #(
    parameter int ADDR_SIZE      = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int PIPE_LATENCY   = 3,
    parameter int PAIRS_PER_PASS = 4
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_rden,
    input  logic [ADDR_SIZE-1:0]  i_rdaddr_A,
    input  logic [ADDR_SIZE-1:0]  i_rdaddr_B,
    input  logic [DATA_WIDTH-1:0] i_bfly_A,
    input  logic [DATA_WIDTH-1:0] i_bfly_B,
    output logic                  o_wren,
    output logic [ADDR_SIZE-1:0]  o_wraddr_A,
    output logic [ADDR_SIZE-1:0]  o_wraddr_B,
    output logic [DATA_WIDTH-1:0] o_wrdata_A,
    output logic [DATA_WIDTH-1:0] o_wrdata_B,
    output logic                  o_busy,
    output logic                  o_pass_done,
    output logic                  o_err_short
);
    localparam int             CW   = $clog2(PAIRS_PER_PASS + 1);
    localparam logic [CW-1:0]  LAST = CW'(PAIRS_PER_PASS - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERR} state_t;

    state_t                  r_state, w_next;
    logic [PIPE_LATENCY-1:0] r_tag_v;
    logic [ADDR_SIZE-1:0]    r_tag_a [PIPE_LATENCY];
    logic [ADDR_SIZE-1:0]    r_tag_b [PIPE_LATENCY];
    logic [CW-1:0]           r_count;
    logic                    r_wren, r_pass_done, r_err;
    logic [ADDR_SIZE-1:0]    r_wraddr_A, r_wraddr_B;
    logic [DATA_WIDTH-1:0]   r_wrdata_A, r_wrdata_B;
    logic                    w_issue, w_any_tag, w_pass_end;

    assign w_issue    = r_tag_v[PIPE_LATENCY-1];
    assign w_any_tag  = |r_tag_v;
    assign w_pass_end = w_issue && (r_count == LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_rden || w_any_tag) w_next = ACTIVE;
            ACTIVE: begin
                if (w_pass_end)
                    w_next = DONE;
                else if (!w_any_tag && !i_rden)
                    w_next = (r_count != '0) ? ERR : IDLE;
            end
            // a one-pair pass can complete again while still in DONE
            DONE: begin
                if (w_pass_end)
                    w_next = DONE;
                else if (w_any_tag || i_rden)
                    w_next = ACTIVE;
                else
                    w_next = IDLE;
            end
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state     <= IDLE;
            r_tag_v     <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                r_tag_a[i] <= '0;
                r_tag_b[i] <= '0;
            end
            r_count     <= '0;
            r_wren      <= 1'b0;
            r_pass_done <= 1'b0;
            r_err       <= 1'b0;
            r_wraddr_A  <= '0;
            r_wraddr_B  <= '0;
            r_wrdata_A  <= '0;
            r_wrdata_B  <= '0;
        end else begin
            r_state <= w_next;
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_a[i] <= r_tag_a[i-1];
                r_tag_b[i] <= r_tag_b[i-1];
            end
            r_tag_v[0] <= i_rden;
            r_tag_a[0] <= i_rdaddr_A;
            r_tag_b[0] <= i_rdaddr_B;

            // addr/data hold their last value across gaps in the tag stream
            r_wren <= w_issue;
            if (w_issue) begin
                r_wraddr_A <= r_tag_a[PIPE_LATENCY-1];
                r_wraddr_B <= r_tag_b[PIPE_LATENCY-1];
                r_wrdata_A <= i_bfly_A;
                r_wrdata_B <= i_bfly_B;
            end

            r_pass_done <= (r_state == DONE);
            if (r_state == ERR) begin
                r_err   <= 1'b1;
                r_count <= '0;
            end else if (w_issue) begin
                r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
            end
        end
    end

    assign o_wren      = r_wren;
    assign o_wraddr_A  = r_wraddr_A;
    assign o_wraddr_B  = r_wraddr_B;
    assign o_wrdata_A  = r_wrdata_A;
    assign o_wrdata_B  = r_wrdata_B;
    assign o_busy      = (r_state != IDLE) || w_any_tag;
    assign o_pass_done = r_pass_done;
    assign o_err_short = r_err;
endmodule
